reg_pipe_m: RTL

- Parametrised successor to the single-stage enabled register: a DEPTH-stage elastic pipeline register for signed fixed-point datapath words.
- Each stage carries a valid bit and uses valid/ready backpressure. Bubbles collapse, and an occupancy count is reported.
- Sits between QFT datapath blocks (e.g. multiplier/adder outputs feeding the state-vector writer) to retime long paths and absorb downstream stalls.

---
 rtl/reg_pipe_m.sv | 90 +++++++++
 1 files changed

// File: rtl/reg_pipe_m.sv
// reg_pipe_m: DEPTH-stage elastic valid/ready pipeline register with bubble collapse and occupancy count.
// Optional REG_PIPE_STALL_CNT_EN adds a saturating stall counter and zeroes out_data while out_valid is low.
module reg_pipe_m #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef REG_PIPE_STALL_CNT_EN
  ,
  output logic [15:0]                stall_cnt
`endif
);

  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]  valid_q;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  rdy;
  logic [CNT_W-1:0]  count_q;
  logic              in_xfer;
  logic              out_xfer;

  // A stage is ready if it is empty or anything downstream of it can move.
  always_comb begin : ready_chain
    logic acc;
    acc = out_ready;
    rdy = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      acc    = acc | ~valid_q[i];
      rdy[i] = acc;
    end
  end

  assign in_ready  = rdy[0] & ~flush;
  assign in_xfer   = in_valid & in_ready;
  assign out_valid = valid_q[DEPTH-1];
  assign out_xfer  = out_valid & out_ready;
  assign count     = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      if (rdy[0]) begin
        valid_q[0] <= in_xfer;
        if (in_xfer) data_q[0] <= in_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (rdy[i]) begin
          valid_q[i] <= valid_q[i-1];
          if (valid_q[i-1]) data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     count_q <= '0;
    else if (flush) count_q <= '0;
    else            count_q <= count_q + CNT_W'(in_xfer) - CNT_W'(out_xfer);
  end

`ifdef REG_PIPE_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (flush)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end

  assign out_data = out_valid ? data_q[DEPTH-1] : '0;
`else
  assign out_data = data_q[DEPTH-1];
`endif

endmodule
